// File: rtl/mips_fetch_queue.sv
// MIPS32 instruction-fetch front end.
// Runs the PC, issues word fetches to instruction memory, and buffers the
// returned words with their next-PC in a small in-order prefetch queue.
// The queue head goes to ID through a valid/ready handshake. A branch
// redirect from EX flushes the queue. Responses that are still in flight
// at the redirect are counted and then discarded when they arrive.
module mips_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic          clk1,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_ir,
  output logic [31:0]   id_npc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]    pc;
  logic [31:0]    slot_npc [DEPTH];
  logic [31:0]    slot_ir  [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  alloc_ptr;
  logic [PW-1:0]  fill_ptr;
  // alloc_cnt: slots holding a request (filled or not); pend_cnt: allocated
  // but not yet filled; drop_cnt: responses still owed for flushed requests.
  logic [CW-1:0]  alloc_cnt;
  logic [CW-1:0]  pend_cnt;
  logic [CW-1:0]  drop_cnt;
  logic           halted;

  logic           accept;
  logic           fill;
  logic           drop;
  logic           pop;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  drop_next;

  // Issue, fill, pop and flush-accounting decisions for this cycle.
  always_comb begin
    imem_req  = rst_n && !halted && !halt && !redirect &&
                (drop_cnt == '0) && (alloc_cnt < CW'(DEPTH));
    imem_addr = pc[AW-1:0];
    accept    = imem_req && imem_gnt;
    fill      = imem_rvalid && (drop_cnt == '0) && !redirect;
    drop      = imem_rvalid && (drop_cnt != '0) && !redirect;
    id_valid  = slot_filled[head_ptr];
    id_ir     = id_valid ? slot_ir[head_ptr]  : '0;
    id_npc    = id_valid ? slot_npc[head_ptr] : '0;
    pop       = id_valid && id_ready && !redirect;
    // Everything still owed by memory after a flush. Once drop_cnt is
    // nonzero nothing new is issued, so pend_cnt is zero then and the sum
    // stays within DEPTH. This also covers a second redirect arriving while
    // earlier flushed responses are still outstanding. The response that
    // arrives in the redirect cycle is discarded here, so it is not counted.
    inflight  = pend_cnt + drop_cnt;
    drop_next = (imem_rvalid && (inflight != '0)) ? inflight - CW'(1) : inflight;
  end

  // PC, pointers, occupancy counters and the sticky halt flag.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
      halted    <= 1'b0;
    end else begin
      halted <= halted | halt;
      if (redirect) begin
        pc        <= redirect_pc;
        head_ptr  <= '0;
        alloc_ptr <= '0;
        fill_ptr  <= '0;
        alloc_cnt <= '0;
        pend_cnt  <= '0;
        drop_cnt  <= drop_next;
      end else begin
        if (accept) begin
          pc        <= pc + 32'd1;
          alloc_ptr <= alloc_ptr + PW'(1);
        end
        if (fill) fill_ptr <= fill_ptr + PW'(1);
        if (pop)  head_ptr <= head_ptr + PW'(1);
        if (drop) drop_cnt <= drop_cnt - CW'(1);
        alloc_cnt <= alloc_cnt + CW'(accept) - CW'(pop);
        pend_cnt  <= pend_cnt + CW'(accept) - CW'(fill);
      end
    end
  end

  // Slot storage: allocate on accept, fill on response, free on pop.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      slot_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_npc[i] <= '0;
        slot_ir[i]  <= '0;
      end
    end else if (redirect) begin
      slot_filled <= '0;
    end else begin
      if (accept) begin
        slot_npc[alloc_ptr]    <= pc + 32'd1;
        slot_filled[alloc_ptr] <= 1'b0;
      end
      if (fill) begin
        slot_ir[fill_ptr]     <= imem_rdata;
        slot_filled[fill_ptr] <= 1'b1;
      end
      if (pop) slot_filled[head_ptr] <= 1'b0;
    end
  end

endmodule
